// File: rtl/graph_mem_server_if.sv
// Request/response bundle between the fetch engine (master) and graph_mem_server (slave),
// including the host load path that fills the graph BRAM.
interface graph_mem_server_if #(
    parameter int DATA_WIDTH      = 32,
    parameter int ADDR_WIDTH      = 32,
    parameter int BRAM_ADDR_WIDTH = 16
);
    // Every strobe is a single-cycle qualifier with no ready: a high data_validin* cycle is one
    // read request, a high load_valid_in cycle is one write, a high data_valid_out* is one response.
    logic [ADDR_WIDTH-1:0]      data_addra;
    logic                       data_validina;
    logic [DATA_WIDTH-1:0]      data_outa;
    logic                       data_valid_outa;
    logic [ADDR_WIDTH-1:0]      data_addrb;
    logic                       data_validinb;
    logic [DATA_WIDTH-1:0]      data_outb;
    logic                       data_valid_outb;
    logic [BRAM_ADDR_WIDTH-1:0] load_addr_in;
    logic [DATA_WIDTH-1:0]      load_data_in;
    logic                       load_valid_in;

    modport master (
        output data_addra, data_validina, data_addrb, data_validinb,
        output load_addr_in, load_data_in, load_valid_in,
        input  data_outa, data_valid_outa, data_outb, data_valid_outb
    );

    modport slave (
        input  data_addra, data_validina, data_addrb, data_validinb,
        input  load_addr_in, load_data_in, load_valid_in,
        output data_outa, data_valid_outa, data_outb, data_valid_outb
    );
endinterface

// File: rtl/graph_mem_server.sv
// Two-port read server over one single-port BRAM: per-port request FIFOs, round-robin
// arbitration with host loads taking priority, and a tag pipeline that routes read data back.
module graph_mem_server #(
    parameter int DATA_WIDTH      = 32,
    parameter int ADDR_WIDTH      = 32,
    parameter int BRAM_ADDR_WIDTH = 16,
    parameter int FIFO_DEPTH      = 8,
    parameter int READ_LATENCY    = 2
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    graph_mem_server_if.slave          req,
    output logic [BRAM_ADDR_WIDTH-1:0] bram_addr_out,
    output logic                       bram_en_out,
    output logic                       bram_we_out,
    output logic [DATA_WIDTH-1:0]      bram_wdata_out,
    input  logic [DATA_WIDTH-1:0]      bram_rdata_in,
    output logic                       overflow_a_out,
    output logic                       overflow_b_out,
    output logic                       idle_out
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    typedef enum logic {PORT_A = 1'b0, PORT_B = 1'b1} port_t;

    logic [BRAM_ADDR_WIDTH-1:0] fifo_a [FIFO_DEPTH];
    logic [BRAM_ADDR_WIDTH-1:0] fifo_b [FIFO_DEPTH];
    logic [PTR_W-1:0]           wr_ptr_a, rd_ptr_a, wr_ptr_b, rd_ptr_b;
    logic [CNT_W-1:0]           count_a, count_b;
    logic                       overflow_a, overflow_b;
    port_t                      last_grant;

    logic                       empty_a, empty_b;
    logic                       grant_a, grant_b;
    logic                       push_a, push_b;
    logic [BRAM_ADDR_WIDTH-1:0] addr_a, addr_b;

    logic [READ_LATENCY:0]      tag_v;
    port_t                      tag_p [READ_LATENCY+1];

    logic [DATA_WIDTH-1:0]      data_outa, data_outb;
    logic                       data_valid_outa, data_valid_outb;

    // Only the low BRAM_ADDR_WIDTH bits of a request address select a word.
    assign addr_a = req.data_addra[BRAM_ADDR_WIDTH-1:0];
    assign addr_b = req.data_addrb[BRAM_ADDR_WIDTH-1:0];

    logic unused_addr_bits;
    assign unused_addr_bits = ^{req.data_addra[ADDR_WIDTH-1:BRAM_ADDR_WIDTH],
                                req.data_addrb[ADDR_WIDTH-1:BRAM_ADDR_WIDTH]};

    always_comb begin
        empty_a = (count_a == '0);
        empty_b = (count_b == '0);
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (!req.load_valid_in) begin
            if (!empty_a && (empty_b || last_grant == PORT_B)) begin
                grant_a = 1'b1;
            end else if (!empty_b) begin
                grant_b = 1'b1;
            end
        end
        // A full FIFO still accepts a request when its head is popped in the same cycle.
        push_a = req.data_validina && ((count_a != DEPTH_C) || grant_a);
        push_b = req.data_validinb && ((count_b != DEPTH_C) || grant_b);
    end

    always_ff @(posedge clk_in) begin
        if (push_a) fifo_a[wr_ptr_a] <= addr_a;
        if (push_b) fifo_b[wr_ptr_b] <= addr_b;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            wr_ptr_a   <= '0;
            rd_ptr_a   <= '0;
            count_a    <= '0;
            wr_ptr_b   <= '0;
            rd_ptr_b   <= '0;
            count_b    <= '0;
            overflow_a <= 1'b0;
            overflow_b <= 1'b0;
            last_grant <= PORT_B;
        end else begin
            if (push_a) wr_ptr_a <= wr_ptr_a + PTR_W'(1);
            if (grant_a) rd_ptr_a <= rd_ptr_a + PTR_W'(1);
            count_a <= count_a + CNT_W'(push_a) - CNT_W'(grant_a);
            if (req.data_validina && !push_a) overflow_a <= 1'b1;

            if (push_b) wr_ptr_b <= wr_ptr_b + PTR_W'(1);
            if (grant_b) rd_ptr_b <= rd_ptr_b + PTR_W'(1);
            count_b <= count_b + CNT_W'(push_b) - CNT_W'(grant_b);
            if (req.data_validinb && !push_b) overflow_b <= 1'b1;

            if (grant_a) last_grant <= PORT_A;
            else if (grant_b) last_grant <= PORT_B;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            bram_en_out    <= 1'b0;
            bram_we_out    <= 1'b0;
            bram_addr_out  <= '0;
            bram_wdata_out <= '0;
        end else if (req.load_valid_in) begin
            bram_en_out    <= 1'b1;
            bram_we_out    <= 1'b1;
            bram_addr_out  <= req.load_addr_in;
            bram_wdata_out <= req.load_data_in;
        end else if (grant_a || grant_b) begin
            bram_en_out    <= 1'b1;
            bram_we_out    <= 1'b0;
            bram_addr_out  <= grant_a ? fifo_a[rd_ptr_a] : fifo_b[rd_ptr_b];
            bram_wdata_out <= '0;
        end else begin
            bram_en_out    <= 1'b0;
            bram_we_out    <= 1'b0;
            bram_addr_out  <= '0;
            bram_wdata_out <= '0;
        end
    end

    // One extra stage beyond READ_LATENCY covers the registered BRAM command.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            tag_v <= '0;
        end else begin
            tag_v[0] <= grant_a || grant_b;
            tag_p[0] <= grant_b ? PORT_B : PORT_A;
            for (int i = 1; i <= READ_LATENCY; i++) begin
                tag_v[i] <= tag_v[i-1];
                tag_p[i] <= tag_p[i-1];
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            data_outa       <= '0;
            data_outb       <= '0;
            data_valid_outa <= 1'b0;
            data_valid_outb <= 1'b0;
        end else begin
            data_valid_outa <= tag_v[READ_LATENCY] && (tag_p[READ_LATENCY] == PORT_A);
            data_valid_outb <= tag_v[READ_LATENCY] && (tag_p[READ_LATENCY] == PORT_B);
            if (tag_v[READ_LATENCY] && tag_p[READ_LATENCY] == PORT_A) data_outa <= bram_rdata_in;
            if (tag_v[READ_LATENCY] && tag_p[READ_LATENCY] == PORT_B) data_outb <= bram_rdata_in;
        end
    end

    assign req.data_outa       = data_outa;
    assign req.data_outb       = data_outb;
    assign req.data_valid_outa = data_valid_outa;
    assign req.data_valid_outb = data_valid_outb;
    assign overflow_a_out      = overflow_a;
    assign overflow_b_out      = overflow_b;
    assign idle_out            = empty_a && empty_b && (tag_v == '0);

endmodule

// File: tb/tb_graph_mem_server.sv
// Bench for graph_mem_server: behavioural BRAM, shadow memory with per-port expected queues,
// a table of single-cycle request vectors, hand-written corner sequences and a randomized phase.
module tb_graph_mem_server;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int BW = 16;
    localparam int FIFO_DEPTH = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [BW-1:0] bram_addr;
    logic          bram_en, bram_we;
    logic [DW-1:0] bram_wdata, bram_rdata;
    logic          ovf_a, ovf_b, idle;

    graph_mem_server_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BRAM_ADDR_WIDTH(BW)) ifc ();

    graph_mem_server #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BRAM_ADDR_WIDTH(BW),
        .FIFO_DEPTH(FIFO_DEPTH), .READ_LATENCY(2)
    ) dut (
        .clk_in(clk), .rst_in(rst), .req(ifc),
        .bram_addr_out(bram_addr), .bram_en_out(bram_en), .bram_we_out(bram_we),
        .bram_wdata_out(bram_wdata), .bram_rdata_in(bram_rdata),
        .overflow_a_out(ovf_a), .overflow_b_out(ovf_b), .idle_out(idle)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Two-cycle read latency BRAM
    logic [DW-1:0] mem [1 << BW];
    logic [DW-1:0] rd1, rd2;
    always @(posedge clk) begin
        if (bram_en && bram_we) mem[bram_addr] <= bram_wdata;
        if (bram_en && !bram_we) rd1 <= mem[bram_addr];
        rd2 <= rd1;
    end
    assign bram_rdata = rd2;

    // ---------------- scoreboard ----------------
    logic [DW-1:0] ref_mem [1 << BW];
    logic [DW-1:0] exp_q_a[$];
    logic [DW-1:0] exp_q_b[$];
    int n_tests = 0;
    int n_fail = 0;
    int n_resp_a, n_resp_b, last_cyc_a, last_cyc_b;
    logic [DW-1:0] last_data_a, last_data_b;
    logic resp_port_q[$];
    int   resp_cyc_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_log();
        n_resp_a = 0;
        n_resp_b = 0;
        resp_port_q.delete();
        resp_cyc_q.delete();
    endtask

    always @(negedge clk) begin
        if (ifc.data_valid_outa) begin
            n_resp_a++;
            last_cyc_a = cyc;
            last_data_a = ifc.data_outa;
            resp_port_q.push_back(1'b0);
            resp_cyc_q.push_back(cyc);
            if (exp_q_a.size() == 0) check("resp_a_unexpected", 32'd1, 32'd0);
            else check("resp_a_data", ifc.data_outa, exp_q_a.pop_front());
        end
        if (ifc.data_valid_outb) begin
            n_resp_b++;
            last_cyc_b = cyc;
            last_data_b = ifc.data_outb;
            resp_port_q.push_back(1'b1);
            resp_cyc_q.push_back(cyc);
            if (exp_q_b.size() == 0) check("resp_b_unexpected", 32'd1, 32'd0);
            else check("resp_b_data", ifc.data_outb, exp_q_b.pop_front());
        end
    end

    // ---------------- driver ----------------
    task automatic idle_inputs();
        ifc.data_validina = 1'b0;
        ifc.data_addra    = '0;
        ifc.data_validinb = 1'b0;
        ifc.data_addrb    = '0;
        ifc.load_valid_in = 1'b0;
        ifc.load_addr_in  = '0;
        ifc.load_data_in  = '0;
    endtask

    // Drives one cycle of inputs; a load updates the shadow memory before reads are predicted.
    task automatic cycle_in(input logic va, input logic [31:0] aa, input logic vb,
                            input logic [31:0] ab, input logic lv, input logic [15:0] la,
                            input logic [31:0] ld, input logic acc_a);
        ifc.data_validina = va;
        ifc.data_addra    = aa;
        ifc.data_validinb = vb;
        ifc.data_addrb    = ab;
        ifc.load_valid_in = lv;
        ifc.load_addr_in  = la;
        ifc.load_data_in  = ld;
        if (lv) ref_mem[la] = ld;
        if (va && acc_a) exp_q_a.push_back(ref_mem[aa[15:0]]);
        if (vb) exp_q_b.push_back(ref_mem[ab[15:0]]);
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    task automatic wait_drain(input string name);
        int k;
        k = 0;
        while ((exp_q_a.size() != 0 || exp_q_b.size() != 0 || !idle) && k < 400) begin
            @(posedge clk);
            #1;
            k++;
        end
        check(name, 32'(k < 400), 32'd1);
        repeat (4) @(posedge clk);
        #1;
    endtask

    // ---------------- vectors ----------------
    typedef struct {
        logic        va;
        logic [31:0] aa;
        logic        vb;
        logic [31:0] ab;
        int          lat_a;
        int          lat_b;
        logic [31:0] da;
        logic [31:0] db;
    } vec_t;
    vec_t vecs [7];

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int t0, bad;
        logic [31:0] aa, ab, ld;
        logic [15:0] la;
        logic va, vb, lv;
        logic [15:0] loaded_q[$];

        vecs[0] = '{1'b1, 32'd1,          1'b1, 32'd2,          4, 5, 32'h11,       32'h22};
        vecs[1] = '{1'b1, 32'd5,          1'b0, 32'd0,          4, 0, 32'hDEADBEEF, 32'h0};
        vecs[2] = '{1'b1, 32'd3,          1'b1, 32'h8000_0005,  5, 4, 32'h33,       32'hDEADBEEF};
        vecs[3] = '{1'b0, 32'd0,          1'b1, 32'd1,          0, 4, 32'h0,        32'h11};
        vecs[4] = '{1'b1, 32'd2,          1'b1, 32'd3,          4, 5, 32'h22,       32'h33};
        vecs[5] = '{1'b1, 32'hFFFF_0002,  1'b0, 32'd0,          4, 0, 32'h22,       32'h0};
        vecs[6] = '{1'b0, 32'd0,          1'b0, 32'd0,          0, 0, 32'h0,        32'h0};

        idle_inputs();
        clear_log();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        check("reset_bram_en", 32'(bram_en), 32'd0);
        check("reset_bram_we", 32'(bram_we), 32'd0);
        check("reset_bram_addr", 32'(bram_addr), 32'd0);
        check("reset_bram_wdata", bram_wdata, 32'd0);
        check("reset_data_outa", ifc.data_outa, 32'd0);
        check("reset_data_outb", ifc.data_outb, 32'd0);
        check("reset_valid_a", 32'(ifc.data_valid_outa), 32'd0);
        check("reset_valid_b", 32'(ifc.data_valid_outb), 32'd0);
        check("reset_idle", 32'(idle), 32'd1);
        check("reset_ovf_a", 32'(ovf_a), 32'd0);
        check("reset_ovf_b", 32'(ovf_b), 32'd0);

        // Preload words 0..127 through the host load path.
        for (int i = 0; i < 128; i++) begin
            case (i)
                1:       ld = 32'h11;
                2:       ld = 32'h22;
                3:       ld = 32'h33;
                5:       ld = 32'hDEADBEEF;
                default: ld = $urandom;
            endcase
            cycle_in(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 16'(i), ld, 1'b1);
        end
        repeat (4) @(posedge clk);
        #1;

        // Single-cycle request patterns from an idle server.
        for (int i = 0; i < 7; i++) begin
            clear_log();
            t0 = cyc + 1;
            cycle_in(vecs[i].va, vecs[i].aa, vecs[i].vb, vecs[i].ab, 1'b0, 16'd0, 32'd0, 1'b1);
            repeat (10) @(posedge clk);
            #1;
            check($sformatf("vec%0d_count_a", i), 32'(n_resp_a), 32'(vecs[i].va));
            check($sformatf("vec%0d_count_b", i), 32'(n_resp_b), 32'(vecs[i].vb));
            if (vecs[i].va) begin
                check($sformatf("vec%0d_lat_a", i), 32'(last_cyc_a - t0), 32'(vecs[i].lat_a));
                check($sformatf("vec%0d_data_a", i), last_data_a, vecs[i].da);
            end
            if (vecs[i].vb) begin
                check($sformatf("vec%0d_lat_b", i), 32'(last_cyc_b - t0), 32'(vecs[i].lat_b));
                check($sformatf("vec%0d_data_b", i), last_data_b, vecs[i].db);
            end
            check($sformatf("vec%0d_idle", i), 32'(idle), 32'd1);
        end

        // Load then an immediate B read with upper address bits set.
        clear_log();
        cycle_in(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 16'h0003, 32'hCAFE0001, 1'b1);
        t0 = cyc + 1;
        cycle_in(1'b0, 32'd0, 1'b1, 32'h1234_0003, 1'b0, 16'd0, 32'd0, 1'b1);
        wait_drain("load_read_drain");
        check("load_read_count_b", 32'(n_resp_b), 32'd1);
        check("load_read_data_b", last_data_b, 32'hCAFE0001);
        check("load_read_lat_b", 32'(last_cyc_b - t0), 32'd4);
        check("load_read_count_a", 32'(n_resp_a), 32'd0);

        // Sustained contention: both ports request every cycle for 10 cycles.
        clear_log();
        for (int i = 0; i < 10; i++)
            cycle_in(1'b1, 32'(i), 1'b1, 32'(100 + i), 1'b0, 16'd0, 32'd0, 1'b1);
        wait_drain("contention_drain");
        check("contention_count_a", 32'(n_resp_a), 32'd10);
        check("contention_count_b", 32'(n_resp_b), 32'd10);
        bad = 0;
        for (int i = 1; i < resp_port_q.size(); i++)
            if (resp_port_q[i] == resp_port_q[i-1] || resp_cyc_q[i] != resp_cyc_q[i-1] + 1) bad++;
        check("contention_alternate", 32'(bad), 32'd0);
        check("contention_ovf_a", 32'(ovf_a), 32'd0);
        check("contention_ovf_b", 32'(ovf_b), 32'd0);

        // Randomized traffic; outstanding reads per port stay below the FIFO depth.
        clear_log();
        for (int i = 0; i < 300; i++) begin
            lv = ($urandom_range(0, 3) == 0);
            la = 16'h0100 + 16'($urandom_range(0, 63));
            ld = $urandom;
            va = ($urandom_range(0, 1) == 1) && (exp_q_a.size() < FIFO_DEPTH);
            vb = ($urandom_range(0, 1) == 1) && (exp_q_b.size() < FIFO_DEPTH);
            aa = ($urandom & 32'hFFFF_0000) | 32'($urandom_range(0, 127));
            ab = ($urandom & 32'hFFFF_0000) | 32'($urandom_range(0, 127));
            if (lv) loaded_q.push_back(la);
            cycle_in(va, aa, vb, ab, lv, la, ld, 1'b1);
        end
        for (int i = 0; i < 150 && loaded_q.size() > 0; i++) begin
            va = ($urandom_range(0, 2) != 0) && (exp_q_a.size() < FIFO_DEPTH);
            vb = ($urandom_range(0, 2) != 0) && (exp_q_b.size() < FIFO_DEPTH);
            aa = 32'(loaded_q[$urandom_range(0, loaded_q.size() - 1)]);
            ab = 32'(loaded_q[$urandom_range(0, loaded_q.size() - 1)]);
            cycle_in(va, aa, vb, ab, 1'b0, 16'd0, 32'd0, 1'b1);
        end
        wait_drain("random_drain");
        check("random_ovf_a", 32'(ovf_a), 32'd0);
        check("random_ovf_b", 32'(ovf_b), 32'd0);
        check("random_idle", 32'(idle), 32'd1);

        // Load held 12 cycles while A sends 10 requests: 8 fit, 2 are dropped.
        clear_log();
        for (int i = 0; i < 12; i++)
            cycle_in(i < 10, 32'(i), 1'b0, 32'd0, 1'b1, 16'h0200, 32'hA5A5_0000 + 32'(i), i < 8);
        check("ovf_no_resp_during_load", 32'(n_resp_a), 32'd0);
        wait_drain("ovf_drain");
        check("ovf_count_a", 32'(n_resp_a), 32'd8);
        check("ovf_flag_a", 32'(ovf_a), 32'd1);
        check("ovf_flag_b", 32'(ovf_b), 32'd0);

        // Reset one cycle after the first grant of three A reads.
        clear_log();
        cycle_in(1'b1, 32'd10, 1'b0, 32'd0, 1'b0, 16'd0, 32'd0, 1'b1);
        cycle_in(1'b1, 32'd11, 1'b0, 32'd0, 1'b0, 16'd0, 32'd0, 1'b1);
        rst = 1'b1;
        ifc.data_validina = 1'b1;
        ifc.data_addra = 32'd12;
        exp_q_a.delete();
        exp_q_b.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle_inputs();
        check("rst_idle", 32'(idle), 32'd1);
        check("rst_ovf_a", 32'(ovf_a), 32'd0);
        check("rst_ovf_b", 32'(ovf_b), 32'd0);
        check("rst_bram_en", 32'(bram_en), 32'd0);
        repeat (12) @(posedge clk);
        #1;
        check("rst_no_resp_a", 32'(n_resp_a), 32'd0);
        check("rst_no_resp_b", 32'(n_resp_b), 32'd0);
        check("rst_idle_after", 32'(idle), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/graph_mem_server.md
Name: graph_mem_server

Overview:
- Responder end of the graph-memory request interface driven by the fetch engine.
- Accepts independent read requests on two request ports (A, B), which have no backpressure.
- Queues each port's requests, arbitrates onto one single-port BRAM, and returns data per port in request order.
- Also owns the host write path that loads graph data into the same BRAM.

Parameters:
- DATA_WIDTH, 32, width of memory words and port data.
- ADDR_WIDTH, 32, width of request addresses on ports A/B.
- BRAM_ADDR_WIDTH, 16, BRAM address width; requests use the low BRAM_ADDR_WIDTH bits and upper bits are ignored.
- FIFO_DEPTH, 8, per-port request FIFO depth; must be a power of two and at least 2.
- READ_LATENCY, 2, BRAM read latency in cycles from en to valid rdata.

Ports:
- clk_in  in  1  single clock.
- rst_in  in  1  synchronous, active-high reset.
- data_addra  in  ADDR_WIDTH  port A read address.
- data_validina  in  1  port A request strobe; one request per high cycle.
- data_outa  out  DATA_WIDTH  port A read data.
- data_valid_outa  out  1  port A response strobe, one-cycle pulse.
- data_addrb, data_validinb, data_outb, data_valid_outb  as port A, for port B.
- load_addr_in  in  BRAM_ADDR_WIDTH  host write address.
- load_data_in  in  DATA_WIDTH  host write data.
- load_valid_in  in  1  host write strobe.
- bram_addr_out  out  BRAM_ADDR_WIDTH  BRAM address.
- bram_en_out  out  1  BRAM enable.
- bram_we_out  out  1  BRAM write enable.
- bram_wdata_out  out  DATA_WIDTH  BRAM write data.
- bram_rdata_in  in  DATA_WIDTH  BRAM read data.
- overflow_a_out, overflow_b_out  out  1  sticky flag: a request was dropped.
- idle_out  out  1  both FIFOs empty and no read in flight.

Behaviour:
- Reset: clears both FIFOs, the tag pipeline, last_grant (set to B, so A wins first) and both overflow flags. All BRAM outputs are 0. data_out* are 0 and data_valid_out* are 0. idle_out is 1.
- Enqueue: on data_validin*, the address is pushed if count < FIFO_DEPTH, or if that FIFO is popped in the same cycle. Otherwise the request is dropped and the port's overflow flag is set; it stays set until reset.
- Issue, one BRAM op per cycle, registered outputs:
  - Priority 1, load_valid_in: drive en=1, we=1, addr, wdata. No read is granted that cycle.
  - Priority 2, reads: if exactly one FIFO is non-empty, grant that port. If both are non-empty, grant the port other than last_grant. On a grant: pop the head, drive en=1, we=0, addr=head, update last_grant, and push {valid=1, port} into the tag pipeline.
  - Otherwise en=0, we=0.
- Tag pipeline is READ_LATENCY+1 stages deep. When a valid tag exits, register bram_rdata_in into data_out of the tagged port and pulse that port's data_valid_out for one cycle. The other port's data_out holds its value.
- Latency: request at cycle t with an empty FIFO and no contention gives data_valid_out at t+READ_LATENCY+2 (t+4 by default). Each contention or load cycle adds 1.
- Throughput: 1 read per cycle in aggregate. Under sustained contention each port gets 1 read per 2 cycles.
- Ordering: responses are in request order within a port. No ordering is guaranteed across ports.
- Simultaneous A and B requests with both FIFOs empty: both are enqueued, A is granted first (after reset), B on the next cycle.
- FIFO pointers wrap modulo FIFO_DEPTH. Count ranges 0..FIFO_DEPTH.
- Reset mid-operation: in-flight reads are discarded, no data_valid_out* pulse follows reset, and queued requests are lost.
- idle_out = both counts 0 and no valid tag in the pipeline, from registered state.

Test Plan:
- Preload mem[5]=0xDEADBEEF via load; A request addr 5 at cycle t -> data_outa=0xDEADBEEF, data_valid_outa high only at t+4; data_valid_outb stays 0.
- Same cycle t: A addr 1 (mem=0x11), B addr 2 (mem=0x22) -> A gets 0x11 at t+4, B gets 0x22 at t+5.
- A and B each request every cycle for 10 cycles, addrs 0..9 and 100..109 -> 10 responses per port, in address order, grants alternate, no overflow.
- Hold load_valid_in 12 cycles while A issues 10 back-to-back requests -> the first 8 are accepted, overflow_a_out=1, and exactly 8 responses follow in order after the load ends; overflow_b_out=0.
- Load mem[0x0003]=0xCAFE0001, then immediately B read of 0x12340003 (upper bits ignored) -> data_outb=0xCAFE0001.
- Issue 3 A reads, then assert rst_in one cycle after the first grant -> no data_valid_outa pulse afterwards; idle_out=1 and overflow flags 0 the cycle after reset.
